// File: rtl/fixlut_pkg.sv
// Shared definitions for the fixed-point LUT sequencer: controller states and
// the chunking helpers used to split the select word into LUT-sized slices.
package fixlut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  function automatic int n_chunks(input int size, input int lut_size);
    return (size + lut_size - 1) / lut_size;
  endfunction

  // Width of chunk c; only the last chunk can be narrower than lut_size.
  function automatic int chunk_bits(input int size, input int lut_size, input int c);
    int rem;
    rem = size - c * lut_size;
    return (rem < lut_size) ? rem : lut_size;
  endfunction

endpackage

// File: rtl/fixlut_seq_ctrl_fixlut.sv
// FixLUT: constant table of every signed sum of +/-fact[j] over a k-bit select.
// The table is built at elaboration, so the hardware is a pure k-input lookup.
module FixLUT #(
  parameter int k = 4,
  parameter int W = 32,
  parameter logic [k-1:0][W-1:0] fact = '0
) (
  input  logic [k-1:0] sel,
  output logic [W-1:0] value
);

  function automatic logic [(2**k)-1:0][W-1:0] build_table();
    logic [(2**k)-1:0][W-1:0] t;
    logic [W-1:0]             s;
    for (int e = 0; e < 2**k; e++) begin
      s = '0;
      for (int j = 0; j < k; j++) begin
        s = e[j] ? (s + fact[j]) : (s - fact[j]);
      end
      t[e] = s;
    end
    return t;
  endfunction

  localparam logic [(2**k)-1:0][W-1:0] TABLE = build_table();

  assign value = TABLE[sel];

endmodule

// File: rtl/fixlut_seq_ctrl.sv
// Sequential fixed-point LUT accumulator: one chunk per cycle through a single
// shared W-bit adder. Define FIXLUT_SAT_EN to saturate instead of wrapping.
module fixlut_seq_ctrl
  import fixlut_pkg::*;
#(
  parameter int size     = 12,
  parameter int lut_size = 4,
  parameter int n_int    = 8,
  parameter int n_mant   = 23,
  parameter logic [size-1:0][n_int+n_mant:0] fact = '0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [size-1:0]         sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [n_int+n_mant:0]   result,
  output logic                    ovf
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds its data stable until that edge.

  localparam int W  = n_int + n_mant + 1;
  localparam int NC = n_chunks(size, lut_size);
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;

  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  fsm_state_e      state_q, state_d;
  logic [size-1:0] sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]    lut_out [NC];
  logic [W-1:0]    chunk_val;
  logic [W:0]      sum_ext;
  logic            add_ovf;
  logic            last_chunk;
  logic            accept;

  for (genvar g = 0; g < NC; g++) begin : g_chunk
    localparam int KB = chunk_bits(size, lut_size, g);
    FixLUT #(
      .k   (KB),
      .W   (W),
      .fact(fact[g*lut_size +: KB])
    ) u_lut (
      .sel  (sel_q[g*lut_size +: KB]),
      .value(lut_out[g])
    );
  end

  assign chunk_val  = lut_out[cnt_q];
  assign sum_ext    = {acc_q[W-1], acc_q} + {chunk_val[W-1], chunk_val};
  // Signed overflow: the carry into the extra sign bit disagrees with bit W-1.
  assign add_ovf    = sum_ext[W] ^ sum_ext[W-1];
  assign last_chunk = (cnt_q == CW'(NC - 1));
  assign accept     = in_valid && (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_RUN;
      ST_RUN:  if (last_chunk) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d = sel_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (accept) begin
      sel_d = sel;
      cnt_d = '0;
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_q + CW'(1);
      ovf_d = ovf_q | add_ovf;
`ifdef FIXLUT_SAT_EN
      // The true sum's sign is the extended bit W; clamp toward it.
      if (add_ovf) acc_d = sum_ext[W] ? SAT_MIN : SAT_MAX;
      else         acc_d = sum_ext[W-1:0];
`else
      acc_d = sum_ext[W-1:0];
`endif
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    result    = acc_q;
    ovf       = ovf_q;
  end

`ifndef FIXLUT_SAT_EN
  logic unused_sat;
  assign unused_sat = ^{SAT_MAX, SAT_MIN};
`endif

endmodule

// File: tb/tb_fixlut_seq_ctrl.sv
// Bench for fixlut_seq_ctrl: three instances (W=12, W=8, size=10) run in
// lockstep against an arithmetic reference model of the signed sum.
module tb_fixlut_seq_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        out_ready;
  logic [11:0] sel;

  logic        ir_a, ov_a, ovf_a;
  logic [11:0] res_a;
  logic        ir_b, ov_b, ovf_b;
  logic [7:0]  res_b;
  logic        ir_c, ov_c, ovf_c;
  logic [11:0] res_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fixlut_seq_ctrl #(
    .size(12), .lut_size(4), .n_int(7), .n_mant(4), .fact({12{12'h010}})
  ) dut_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir_a), .sel(sel),
    .out_valid(ov_a), .out_ready(out_ready), .result(res_a), .ovf(ovf_a)
  );

  fixlut_seq_ctrl #(
    .size(12), .lut_size(4), .n_int(3), .n_mant(4), .fact({12{8'h10}})
  ) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir_b), .sel(sel),
    .out_valid(ov_b), .out_ready(out_ready), .result(res_b), .ovf(ovf_b)
  );

  fixlut_seq_ctrl #(
    .size(10), .lut_size(4), .n_int(7), .n_mant(4), .fact({10{12'h010}})
  ) dut_c (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir_c), .sel(sel[9:0]),
    .out_valid(ov_c), .out_ready(out_ready), .result(res_c), .ovf(ovf_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: every fact is 1.0 (16 LSBs); sum chunk by chunk in 4-bit groups,
  // then wrap or clamp the running total to a w-bit signed range.
  function automatic void model(input int sz, input int w, input logic [11:0] s,
                                output logic [31:0] res, output logic ov);
    longint acc, cs, t, mx, mn, m;
    acc = 0;
    ov  = 1'b0;
    mx  = (longint'(1) << (w - 1)) - 1;
    mn  = -(longint'(1) << (w - 1));
    m   = (longint'(1) << w) - 1;
    for (int c = 0; c * 4 < sz; c++) begin
      cs = 0;
      for (int j = c * 4; j < c * 4 + 4 && j < sz; j++) cs += s[j] ? 16 : -16;
      t = acc + cs;
      if (t > mx || t < mn) begin
        ov = 1'b1;
`ifdef FIXLUT_SAT_EN
        t = (t > mx) ? mx : mn;
`else
        t = t & m;
        if (t > mx) t = t - (m + 1);
`endif
      end
      acc = t;
    end
    res = 32'(acc & m);
  endfunction

  task automatic check_outputs(input string tag, input logic [31:0] ea, input logic ea_o,
                               input logic [31:0] eb, input logic eb_o,
                               input logic [31:0] ec, input logic ec_o);
    check({tag, "_valid"}, {29'd0, ov_a, ov_b, ov_c}, 32'h7);
    check({tag, "_res_a"}, 32'(res_a), ea);
    check({tag, "_ovf_a"}, 32'(ovf_a), 32'(ea_o));
    check({tag, "_res_b"}, 32'(res_b), eb);
    check({tag, "_ovf_b"}, 32'(ovf_b), 32'(eb_o));
    check({tag, "_res_c"}, 32'(res_c), ec);
    check({tag, "_ovf_c"}, 32'(ovf_c), 32'(ec_o));
  endtask

  task automatic run_txn(input logic [11:0] s, input int hold);
    logic [31:0] ea, eb, ec;
    logic        oa, ob, oc;
    int          n, lat;
    model(12, 12, s, ea, oa);
    model(12, 8,  s, eb, ob);
    model(10, 12, s, ec, oc);
    n = 0;
    while (!ir_a && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", {29'd0, ir_a, ir_b, ir_c}, 32'h7);
    in_valid  = 1'b1;
    sel       = s;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'($urandom);
    sel      = 12'($urandom);
    lat = 0;
    while (!ov_a && lat < 10) begin
      check("busy_ready", {29'd0, ir_a, ir_b, ir_c}, 32'h0);
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), 32'd3);
    check_outputs("done", ea, oa, eb, ob, ec, oc);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      sel      = 12'($urandom);
      @(posedge clk); #1;
      check_outputs("hold", ea, oa, eb, ob, ec, oc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("after_hs", {28'd0, ov_a, ov_b, ov_c, ir_a & ir_b & ir_c}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {29'd0, ir_a, ir_b, ir_c}, 32'h7);
    check("rst_valid", {29'd0, ov_a, ov_b, ov_c}, 32'h0);
    check("rst_res",   {res_a, res_b, res_c}, 32'h0);
    check("rst_ovf",   {29'd0, ovf_a, ovf_b, ovf_c}, 32'h0);
    rstn = 1'b1;

    run_txn(12'hFFF, 0);
    run_txn(12'h000, 0);
    run_txn(12'hF0F, 0);
    run_txn(12'h5A3, 5);

    // Abort a request two cycles into RUN.
    in_valid = 1'b1;
    sel      = 12'hABC;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check("abort_valid", {29'd0, ov_a, ov_b, ov_c}, 32'h0);
    check("abort_ready", {29'd0, ir_a, ir_b, ir_c}, 32'h7);
    check("abort_res",   {res_a, res_b, res_c}, 32'h0);
    check("abort_ovf",   {29'd0, ovf_a, ovf_b, ovf_c}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_quiet", {29'd0, ov_a, ov_b, ov_c}, 32'h0);
    end

    run_txn(12'h3FF, 1);
    for (int i = 0; i < 20; i++) run_txn(12'($urandom), $urandom_range(0, 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
